// File: rtl/sr_latch_ctrl.sv
// Round-robin scheduler sharing one SR latch among NUM_CH requesters.
// Each grant runs: en setup, set pulse, hold, sample q, then release en to clear the latch.
module sr_latch_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int SET_W    = 1,
    parameter int HOLD_CYC = 4,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant,
    output logic              latch_set,
    output logic              latch_en,
    input  logic              latch_q,
    output logic              done,
    output logic              result,
    output logic              abort,
    output logic              stuck,
    output logic              busy
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int SUM_W = IDX_W + 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] EN_SETUP = 3'd1;
    localparam logic [2:0] SET      = 3'd2;
    localparam logic [2:0] HOLD     = 3'd3;
    localparam logic [2:0] SAMPLE   = 3'd4;
    localparam logic [2:0] RELEASE  = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] next_ptr;
    logic [SUM_W-1:0] sum;
    logic             pick_valid;
    logic             owner_req;

    // First requesting channel at or above the pointer, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        cand       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, ptr} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_CH)) begin
                sum = sum - SUM_W'(NUM_CH);
            end
            cand = sum[IDX_W-1:0];
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign next_ptr  = (pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + IDX_W'(1);
    assign owner_req = |(req & grant);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            grant     <= '0;
            latch_set <= 1'b0;
            latch_en  <= 1'b0;
            done      <= 1'b0;
            result    <= 1'b0;
            abort     <= 1'b0;
            stuck     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant    <= NUM_CH'(1) << pick_idx;
                        latch_en <= 1'b1;
                        busy     <= 1'b1;
                        ptr      <= next_ptr;
                        state    <= EN_SETUP;
                    end
                end
                EN_SETUP: begin
                    // A latch already high before any set pulse means it failed to clear.
                    if (latch_q) begin
                        stuck <= 1'b1;
                    end
                    if (!owner_req) begin
                        grant     <= '0;
                        latch_en  <= 1'b0;
                        latch_set <= 1'b0;
                        abort     <= 1'b1;
                        cnt       <= '0;
                        state     <= RELEASE;
                    end else begin
                        latch_set <= 1'b1;
                        cnt       <= CNT_W'(SET_W - 1);
                        state     <= SET;
                    end
                end
                SET: begin
                    if (!owner_req) begin
                        grant     <= '0;
                        latch_en  <= 1'b0;
                        latch_set <= 1'b0;
                        abort     <= 1'b1;
                        cnt       <= '0;
                        state     <= RELEASE;
                    end else if (cnt == '0) begin
                        latch_set <= 1'b0;
                        cnt       <= CNT_W'(HOLD_CYC - 1);
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!owner_req) begin
                        grant     <= '0;
                        latch_en  <= 1'b0;
                        latch_set <= 1'b0;
                        abort     <= 1'b1;
                        cnt       <= '0;
                        state     <= RELEASE;
                    end else if (cnt == '0) begin
                        result <= latch_q;
                        done   <= 1'b1;
                        state  <= SAMPLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    grant    <= '0;
                    latch_en <= 1'b0;
                    state    <= RELEASE;
                end
                RELEASE: begin
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    grant     <= '0;
                    latch_en  <= 1'b0;
                    latch_set <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: two instances (SET_W=1/HOLD=4 and SET_W=3/HOLD=1) checked every
// cycle against a transaction-offset model, plus directed scenarios with literal expectations.
module tb_sr_latch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       force_q;

    logic [3:0] grant_a  [2];
    logic       set_a    [2];
    logic       en_a     [2];
    logic       q_a      [2];
    logic       done_a   [2];
    logic       result_a [2];
    logic       abort_a  [2];
    logic       stuck_a  [2];
    logic       busy_a   [2];
    logic       qlat0;
    logic       qlat1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int   m_t     [2];
    int   m_owner [2];
    int   m_ptr   [2];
    logic m_ab    [2];
    logic m_res   [2];
    logic m_stk   [2];

    always #5 clk = ~clk;

    sr_latch_ctrl #(.NUM_CH(4), .SET_W(1), .HOLD_CYC(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .req(req), .grant(grant_a[0]), .latch_set(set_a[0]),
        .latch_en(en_a[0]), .latch_q(q_a[0]), .done(done_a[0]), .result(result_a[0]),
        .abort(abort_a[0]), .stuck(stuck_a[0]), .busy(busy_a[0])
    );

    sr_latch_ctrl #(.NUM_CH(4), .SET_W(3), .HOLD_CYC(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .req(req), .grant(grant_a[1]), .latch_set(set_a[1]),
        .latch_en(en_a[1]), .latch_q(q_a[1]), .done(done_a[1]), .result(result_a[1]),
        .abort(abort_a[1]), .stuck(stuck_a[1]), .busy(busy_a[1])
    );

    // SR latch stand-ins: set while enabled, cleared whenever en is low; force_q emulates a stuck cell.
    always @* begin
        if (!en_a[0]) qlat0 = 1'b0;
        else if (set_a[0]) qlat0 = 1'b1;
    end
    always @* begin
        if (!en_a[1]) qlat1 = 1'b0;
        else if (set_a[1]) qlat1 = 1'b1;
    end
    assign q_a[0] = qlat0 | force_q;
    assign q_a[1] = qlat1 | force_q;

    function automatic int swOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int hcOf(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check1(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s inst%0d: got %0h, want %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic check1b(input string name, input int k, input logic act, input logic exp);
        check1(name, k, {3'b000, act}, {3'b000, exp});
    endtask

    // m_t is the 1-based cycle offset inside a transaction (0 = idle); the done cycle is 2+SET_W+HOLD_CYC.
    task automatic modelStep(input int k);
        int  lcyc;
        int  c;
        bit  found;
        lcyc  = 2 + swOf(k) + hcOf(k);
        found = 1'b0;
        if (m_t[k] == 0) begin
            if (req != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    c = (m_ptr[k] + i) % 4;
                    if (!found && req[c]) begin
                        found      = 1'b1;
                        m_owner[k] = c;
                    end
                end
                m_ptr[k] = (m_owner[k] + 1) % 4;
                m_t[k]   = 1;
            end
        end else if (m_ab[k] || m_t[k] == lcyc + 1) begin
            m_t[k]  = 0;
            m_ab[k] = 1'b0;
        end else begin
            if (m_t[k] == 1 && q_a[k]) m_stk[k] = 1'b1;
            if (m_t[k] <= lcyc - 1 && !req[m_owner[k]]) begin
                m_ab[k] = 1'b1;
                m_t[k]  = lcyc + 1;
            end else begin
                if (m_t[k] == lcyc - 1) m_res[k] = q_a[k];
                m_t[k] = m_t[k] + 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_t[k] = 0; m_owner[k] = 0; m_ptr[k] = 0;
                m_ab[k] = 1'b0; m_res[k] = 1'b0; m_stk[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) modelStep(k);
        end
    end

    task automatic checkOutput(input int k);
        int         lcyc;
        logic       live;
        logic [3:0] eg;
        lcyc = 2 + swOf(k) + hcOf(k);
        live = (m_t[k] != 0) && (m_t[k] <= lcyc) && !m_ab[k];
        eg   = live ? (4'b0001 << m_owner[k]) : 4'b0000;
        check1 ("grant",     k, grant_a[k],  eg);
        check1b("latch_en",  k, en_a[k],     live);
        check1b("latch_set", k, set_a[k],    !m_ab[k] && m_t[k] >= 2 && m_t[k] <= 1 + swOf(k));
        check1b("done",      k, done_a[k],   !m_ab[k] && m_t[k] == lcyc);
        check1b("abort",     k, abort_a[k],  m_ab[k]);
        check1b("result",    k, result_a[k], m_res[k]);
        check1b("stuck",     k, stuck_a[k],  m_stk[k]);
        check1b("busy",      k, busy_a[k],   m_t[k] != 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) checkOutput(k);
        end
    end

    task automatic waitCycle();
        @(negedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic f);
        req     = r;
        force_q = f;
    endtask

    task automatic applyReset(input int n);
        rst = 1'b0;
        repeat (n) waitCycle();
        rst = 1'b1;
    endtask

    task automatic waitIdle();
        int c = 0;
        while ((busy_a[0] || busy_a[1]) && c < 40) begin
            waitCycle();
            c++;
        end
        check1b("idle_wait", 0, busy_a[0] | busy_a[1], 1'b0);
    endtask

    task automatic waitGrant(input int k);
        int c = 0;
        do begin
            waitCycle();
            c++;
        end while (grant_a[k] == 4'b0000 && c < 30);
        check1b("grant_wait", k, grant_a[k] != 4'b0000, 1'b1);
    endtask

    task automatic waitDone(input int k);
        int c = 0;
        do begin
            waitCycle();
            c++;
        end while (!done_a[k] && c < 40);
        check1b("done_wait", k, done_a[k], 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] seq [4];
        logic [3:0] prevg;
        logic [3:0] gnext;
        logic [3:0] r;
        int         set_cnt;
        int         done_t;
        int         n;
        int         cyc;

        rst = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        repeat (3) waitCycle();
        chk_en = 1'b1;

        // Reset holds everything low even with all channels requesting.
        applyStimulus(4'b1111, 1'b0);
        waitCycle();
        check1 ("rst_grant", 0, grant_a[0], 4'b0000);
        check1b("rst_en",    0, en_a[0],    1'b0);
        check1b("rst_set",   0, set_a[0],   1'b0);
        check1b("rst_busy",  0, busy_a[0],  1'b0);
        check1b("rst_done",  0, done_a[0],  1'b0);
        check1b("rst_stuck", 0, stuck_a[0], 1'b0);
        rst = 1'b1;
        waitCycle();
        check1 ("first_grant", 0, grant_a[0], 4'b0001);
        check1b("first_en",    0, en_a[0],    1'b1);
        check1b("first_busy",  0, busy_a[0],  1'b1);
        applyStimulus(4'b0000, 1'b0);
        waitIdle();

        // Single capture on channel 1.
        applyStimulus(4'b0010, 1'b0);
        waitGrant(0);
        check1("cap_grant", 0, grant_a[0], 4'b0010);
        set_cnt = 0;
        done_t  = 0;
        for (int t = 2; t <= 8; t++) begin
            waitCycle();
            if (set_a[0]) set_cnt++;
            if (done_a[0] && done_t == 0) done_t = t;
            if (t == 7) check1b("cap_result", 0, result_a[0], 1'b1);
            if (t == 8) begin
                check1b("cap_rel_en", 0, en_a[0], 1'b0);
                check1 ("cap_rel_grant", 0, grant_a[0], 4'b0000);
                check1b("cap_rel_q", 0, q_a[0], 1'b0);
            end
        end
        check1("cap_set_len", 0, 4'(set_cnt), 4'd1);
        check1("cap_done_t",  0, 4'(done_t),  4'd7);
        applyStimulus(4'b0000, 1'b0);
        waitIdle();

        // Round-robin with all channels requesting, then wrap back to channel 0.
        applyReset(2);
        applyStimulus(4'b1111, 1'b0);
        for (int i = 0; i < 4; i++) seq[i] = 4'b0000;
        prevg = 4'b0000;
        n     = 0;
        cyc   = 0;
        while (n < 4 && cyc < 100) begin
            waitCycle();
            cyc++;
            if (grant_a[0] != 4'b0000 && prevg == 4'b0000) begin
                seq[n] = grant_a[0];
                n++;
            end
            prevg = grant_a[0];
        end
        applyStimulus(4'b1001, 1'b0);
        gnext = 4'b0000;
        cyc   = 0;
        while (gnext == 4'b0000 && cyc < 40) begin
            waitCycle();
            cyc++;
            if (grant_a[0] != 4'b0000 && prevg == 4'b0000) gnext = grant_a[0];
            prevg = grant_a[0];
        end
        check1("rr0",   0, seq[0], 4'b0001);
        check1("rr1",   0, seq[1], 4'b0010);
        check1("rr2",   0, seq[2], 4'b0100);
        check1("rr3",   0, seq[3], 4'b1000);
        check1("rr_wrap", 0, gnext, 4'b0001);
        applyStimulus(4'b0000, 1'b0);
        waitIdle();

        // Abort: owner drops its request in the second hold cycle.
        applyStimulus(4'b0100, 1'b0);
        waitGrant(0);
        check1("ab_grant", 0, grant_a[0], 4'b0100);
        repeat (3) waitCycle();
        applyStimulus(4'b0000, 1'b0);
        waitCycle();
        check1b("ab_pulse",  0, abort_a[0],  1'b1);
        check1b("ab_done",   0, done_a[0],   1'b0);
        check1 ("ab_grant0", 0, grant_a[0],  4'b0000);
        check1b("ab_en",     0, en_a[0],     1'b0);
        check1b("ab_result", 0, result_a[0], 1'b1);
        waitCycle();
        check1b("ab_one_cyc", 0, abort_a[0], 1'b0);
        check1b("ab_idle",    0, busy_a[0],  1'b0);

        // Stuck latch: q already high when the transaction starts.
        applyReset(2);
        applyStimulus(4'b0001, 1'b1);
        waitGrant(0);
        check1b("stk_before", 0, stuck_a[0], 1'b0);
        waitCycle();
        check1b("stk_set", 0, stuck_a[0], 1'b1);
        applyStimulus(4'b0001, 1'b0);
        waitDone(0);
        applyStimulus(4'b0000, 1'b0);
        waitIdle();
        applyStimulus(4'b0010, 1'b0);
        waitDone(0);
        applyStimulus(4'b0000, 1'b0);
        waitIdle();
        check1b("stk_sticky0", 0, stuck_a[0], 1'b1);
        check1b("stk_sticky1", 1, stuck_a[1], 1'b1);
        applyReset(2);
        check1b("stk_cleared", 0, stuck_a[0], 1'b0);

        // SET_W=3, HOLD_CYC=1 instance timing.
        applyStimulus(4'b0001, 1'b0);
        waitGrant(1);
        set_cnt = 0;
        done_t  = 0;
        for (int t = 2; t <= 7; t++) begin
            waitCycle();
            if (set_a[1]) set_cnt++;
            if (done_a[1] && done_t == 0) done_t = t;
        end
        check1("w3_set_len", 1, 4'(set_cnt), 4'd3);
        check1("w3_done_t",  1, 4'(done_t),  4'd6);
        applyStimulus(4'b0000, 1'b0);
        waitIdle();

        // Asynchronous reset during the set pulse.
        applyStimulus(4'b0001, 1'b0);
        waitGrant(1);
        waitCycle();
        check1b("w3_in_set", 1, set_a[1], 1'b1);
        rst = 1'b0;
        #1;
        check1b("arst_set",   1, set_a[1],   1'b0);
        check1b("arst_en",    1, en_a[1],    1'b0);
        check1 ("arst_grant", 1, grant_a[1], 4'b0000);
        check1b("arst_busy",  1, busy_a[1],  1'b0);
        check1b("arst_en0",   0, en_a[0],    1'b0);
        waitCycle();
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0);

        // Randomized traffic: request toggles, stuck-latch glitches, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            waitCycle();
            r = req;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            end
            rst = ($urandom_range(0, 599) != 0);
            applyStimulus(r, $urandom_range(0, 29) == 0);
        end
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        repeat (2) waitCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
